// File: rtl/recovery_sequencer_pkg.sv
// Shared core types for the branch-recovery path: address, ROB index and sequencer states.
package recovery_sequencer_pkg;

  localparam int ROB_DEPTH_DEFAULT = 32;

  typedef logic [31:0] address_t;
  typedef logic [$clog2(ROB_DEPTH_DEFAULT)-1:0] rob_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WALK     = 2'd2,
    ST_REDIRECT = 2'd3
  } rec_state_e;

endpackage

// File: rtl/recovery_sequencer.sv
// Mispredict recovery: flush the pipe, unwind rename youngest-first, then redirect fetch.
// Latency: FLUSH at T+1, REDIRECT at T+2+n plus any walk_ready stall cycles; walk holds while walk_ready=0.
module recovery_sequencer
  import recovery_sequencer_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mispredict_valid,
  input  address_t             mispredict_target,
  input  logic [ROB_IDX_W-1:0] mispredict_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_tail,
  output logic                 walk_valid,
  output logic [ROB_IDX_W-1:0] walk_idx,
  input  logic                 walk_ready,
  output logic                 flush_req,
  output logic                 stall_req,
  output logic                 load_pc_we,
  output address_t             load_pc_new_pc,
  output logic                 busy,
  output logic [15:0]          recovery_count
);

  localparam logic [ROB_IDX_W-1:0] IDX_ONE = ROB_IDX_W'(1);

  rec_state_e           state;
  address_t             target_q;
  logic [ROB_IDX_W-1:0] stop_idx;
  logic                 walk_empty;
  logic [ROB_IDX_W-1:0] walk_len;

  // Entries younger than the branch; power-of-two depth makes the wrap free.
  assign walk_len = rob_tail - mispredict_rob_idx - IDX_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      target_q       <= '0;
      stop_idx       <= '0;
      walk_empty     <= 1'b0;
      walk_valid     <= 1'b0;
      walk_idx       <= '0;
      flush_req      <= 1'b0;
      stall_req      <= 1'b0;
      load_pc_we     <= 1'b0;
      load_pc_new_pc <= '0;
      busy           <= 1'b0;
      recovery_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mispredict_valid) begin
            state      <= ST_FLUSH;
            target_q   <= mispredict_target;
            stop_idx   <= mispredict_rob_idx + IDX_ONE;
            walk_idx   <= rob_tail - IDX_ONE;
            walk_empty <= (walk_len == '0);
            flush_req  <= 1'b1;
            stall_req  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_req <= 1'b0;
          if (walk_empty) begin
            state          <= ST_REDIRECT;
            load_pc_we     <= 1'b1;
            load_pc_new_pc <= target_q;
          end else begin
            state      <= ST_WALK;
            walk_valid <= 1'b1;
          end
        end
        ST_WALK: begin
          if (walk_ready) begin
            // The entry just above the branch is the last one restored.
            if (walk_idx == stop_idx) begin
              state          <= ST_REDIRECT;
              walk_valid     <= 1'b0;
              load_pc_we     <= 1'b1;
              load_pc_new_pc <= target_q;
            end else begin
              walk_idx <= walk_idx - IDX_ONE;
            end
          end
        end
        ST_REDIRECT: begin
          state          <= ST_IDLE;
          load_pc_we     <= 1'b0;
          load_pc_new_pc <= '0;
          stall_req      <= 1'b0;
          busy           <= 1'b0;
          if (recovery_count != 16'hFFFF) recovery_count <= recovery_count + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_sequencer.sv
// Bench for recovery_sequencer: directed table, corner sequences and randomized recoveries.
module tb_recovery_sequencer;
  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mispredict_valid;
  logic [31:0] mispredict_target;
  logic [4:0]  mispredict_rob_idx;
  logic [4:0]  rob_tail;
  logic        walk_valid;
  logic [4:0]  walk_idx;
  logic        walk_ready;
  logic        flush_req, stall_req, load_pc_we, busy;
  logic [31:0] load_pc_new_pc;
  logic [15:0] recovery_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int last_walked;
  int first_walked;

  always #5 clk = ~clk;

  recovery_sequencer #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .mispredict_valid(mispredict_valid), .mispredict_target(mispredict_target),
    .mispredict_rob_idx(mispredict_rob_idx), .rob_tail(rob_tail),
    .walk_valid(walk_valid), .walk_idx(walk_idx), .walk_ready(walk_ready),
    .flush_req(flush_req), .stall_req(stall_req), .load_pc_we(load_pc_we),
    .load_pc_new_pc(load_pc_new_pc), .busy(busy), .recovery_count(recovery_count)
  );

  typedef struct {
    int          idx;
    int          tail;
    logic [31:0] target;
    int          mode;       // 0: ready held 1, 1: random ready, 2: two low cycles on the second step
    int          exp_first;  // first walked entry, -1 when nothing walks
    int          exp_last;   // last walked entry, -1 when nothing walks
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stray_inputs();
    mispredict_valid   = 1'($urandom_range(0, 1));
    mispredict_rob_idx = 5'($urandom);
    rob_tail           = 5'($urandom);
    mispredict_target  = $urandom;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stall"}, stall_req, 0);
    chk({tag, "_flush"}, flush_req, 0);
    chk({tag, "_walk_valid"}, walk_valid, 0);
    chk({tag, "_load_pc_we"}, load_pc_we, 0);
    chk({tag, "_new_pc"}, load_pc_new_pc, 0);
    chk({tag, "_count"}, recovery_count, 32'(exp_count));
  endtask

  // Reference: the walk order is just tail-1, tail-2, ... down to idx+1, modulo D.
  task automatic recover(input int idx, input int tail, input logic [31:0] target, input int mode);
    int q[$];
    int n, lows, cyc;
    bit r;
    n = ((tail - idx - 1) % D + D) % D;
    for (int k = 0; k < n; k++) q.push_back(((tail - 1 - k) % D + D) % D);
    first_walked = -1;
    last_walked  = -1;
    lows = 0;
    mispredict_valid   = 1'b1;
    mispredict_rob_idx = 5'(idx);
    rob_tail           = 5'(tail);
    mispredict_target  = target;
    tick();
    chk("flush_req", flush_req, 1);
    chk("flush_stall", stall_req, 1);
    chk("flush_busy", busy, 1);
    chk("flush_walk_valid", walk_valid, 0);
    chk("flush_load_pc_we", load_pc_we, 0);
    chk("flush_new_pc", load_pc_new_pc, 0);
    stray_inputs();
    walk_ready = 1'($urandom_range(0, 1));
    tick();
    cyc = 0;
    while (q.size() > 0) begin
      if (cyc > 400) begin
        chk("walk_timeout", 1, 0);
        break;
      end
      chk("walk_valid", walk_valid, 1);
      chk("walk_idx", 32'(walk_idx), 32'(q[0]));
      chk("walk_flush", flush_req, 0);
      chk("walk_stall", stall_req, 1);
      chk("walk_load_pc_we", load_pc_we, 0);
      if (first_walked < 0) first_walked = int'(walk_idx);
      case (mode)
        0: r = 1'b1;
        2: r = !(q.size() == n - 1 && lows < 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (!r) lows++;
      walk_ready = r;
      if (r) last_walked = q.pop_front();
      stray_inputs();
      tick();
      cyc++;
    end
    chk("redir_load_pc_we", load_pc_we, 1);
    chk("redir_new_pc", load_pc_new_pc, target);
    chk("redir_walk_valid", walk_valid, 0);
    chk("redir_stall", stall_req, 1);
    chk("redir_busy", busy, 1);
    if (mode == 2) chk("redir_lows", 32'(lows), 2);
    // A mispredict seen in REDIRECT must not start another recovery.
    mispredict_valid = 1'b1;
    walk_ready = 1'b1;
    tick();
    mispredict_valid = 1'b0;
    exp_count++;
    check_idle("post");
  endtask

  vec_t vecs[6];

  initial begin
    rst_n = 1'b0;
    mispredict_valid = 1'b0;
    mispredict_target = '0;
    mispredict_rob_idx = '0;
    rob_tail = '0;
    walk_ready = 1'b1;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    vecs[0] = '{idx: 5,  tail: 9, target: 32'h0000_1000, mode: 0, exp_first: 8,  exp_last: 6};
    vecs[1] = '{idx: 30, tail: 2, target: 32'h0000_2000, mode: 0, exp_first: 1,  exp_last: 31};
    vecs[2] = '{idx: 7,  tail: 8, target: 32'h0040_0100, mode: 0, exp_first: -1, exp_last: -1};
    vecs[3] = '{idx: 5,  tail: 5, target: 32'hDEAD_BEEC, mode: 0, exp_first: 4,  exp_last: 6};
    vecs[4] = '{idx: 0,  tail: 0, target: 32'h1234_5678, mode: 1, exp_first: 31, exp_last: 1};
    vecs[5] = '{idx: 5,  tail: 9, target: 32'h8000_0004, mode: 2, exp_first: 8,  exp_last: 6};

    foreach (vecs[i]) begin
      recover(vecs[i].idx, vecs[i].tail, vecs[i].target, vecs[i].mode);
      chk("vec_first_walked", 32'(first_walked), 32'(vecs[i].exp_first));
      chk("vec_last_walked", 32'(last_walked), 32'(vecs[i].exp_last));
    end

    for (int t = 0; t < 20; t++) begin
      recover($urandom_range(0, D - 1), $urandom_range(0, D - 1), $urandom, 1);
    end

    // Reset in the middle of a walk abandons the recovery without a redirect.
    mispredict_valid = 1'b1;
    mispredict_rob_idx = 5'd3;
    rob_tail = 5'd20;
    mispredict_target = 32'hCAFE_0000;
    walk_ready = 1'b1;
    tick();
    mispredict_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("pre_reset_walk_valid", walk_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    check_idle("midwalk_reset");
    chk("midwalk_reset_walk_idx", 32'(walk_idx), 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("after_reset_load_pc_we", load_pc_we, 0);
      chk("after_reset_busy", busy, 0);
    end
    recover(10, 12, 32'h0000_0ABC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
